// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, coordinate/address types and the rectangle writer's state encoding.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = 4;
    localparam int ADDR_W   = 19;

    typedef logic [9:0]        coord_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE,
        FILL
    } wr_state_t;

    // y * 640 as (y * 512) + (y * 128) so no multiplier is inferred
    function automatic addr_t row_base_of(input coord_t y);
        addr_t yw;
        yw = addr_t'(y);
        return (yw << 9) + (yw << 7);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Column / row-base counters for a rectangle fill; tracks the pixel currently on the write port.
module fb_addr_gen
    import vga_pkg::*;
(
    input  logic   clk,
    input  logic   load,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    input  logic   advance,
    output addr_t  addr,
    output logic   last
);

    coord_t x_cur;
    coord_t x_lo;
    coord_t x_hi;
    coord_t y_cur;
    coord_t y_hi;
    addr_t  row_base;
    logic   row_end;

    // Pure datapath: every field is reloaded on each accepted command, so no reset
    always_ff @(posedge clk) begin
        if (load) begin
            x_cur    <= x0;
            x_lo     <= x0;
            x_hi     <= x1;
            y_cur    <= y0;
            y_hi     <= y1;
            row_base <= row_base_of(y0);
        end else if (advance) begin
            if (row_end) begin
                x_cur    <= x_lo;
                y_cur    <= y_cur + 10'd1;
                row_base <= row_base + addr_t'(H_ACTIVE);
            end else begin
                x_cur <= x_cur + 10'd1;
            end
        end
    end

    assign row_end = (x_cur == x_hi);
    assign last    = row_end && (y_cur == y_hi);

    // Address of the pixel that follows the current one in raster order
    assign addr = row_end ? (row_base + addr_t'(H_ACTIVE) + addr_t'(x_lo))
                          : (row_base + addr_t'(x_cur) + addr_t'(1));

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine: validates a command, then streams one frame-buffer write per clock in raster order.
module fb_rect_writer
    import vga_pkg::*;
(
    input  logic              clk_100m,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [9:0]        cmd_y0,
    input  logic [9:0]        cmd_x1,
    input  logic [9:0]        cmd_y1,
    input  logic [PIX_W-1:0]  cmd_color,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              bram_we,
    output logic [PIX_W-1:0]  bram_din
);

    wr_state_t state;
    logic      accept;
    logic      cmd_bad;
    logic      gen_load;
    logic      gen_advance;
    addr_t     gen_addr;
    logic      gen_last;

    assign accept  = cmd_valid && cmd_ready && (state == IDLE);
    assign cmd_bad = (cmd_x0 > cmd_x1) || (cmd_y0 > cmd_y1) ||
                     (cmd_x1 >= 10'(H_ACTIVE)) || (cmd_y1 >= 10'(V_ACTIVE));

    assign gen_load    = accept && !cmd_bad;
    assign gen_advance = (state == FILL) && !gen_last;

    fb_addr_gen u_addr_gen (
        .clk     (clk_100m),
        .load    (gen_load),
        .x0      (cmd_x0),
        .y0      (cmd_y0),
        .x1      (cmd_x1),
        .y1      (cmd_y1),
        .advance (gen_advance),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    always_ff @(posedge clk_100m) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            state     <= FILL;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            bram_en   <= 1'b1;
                            bram_we   <= 1'b1;
                            bram_addr <= row_base_of(cmd_y0) + addr_t'(cmd_x0);
                            bram_din  <= cmd_color;
                        end
                    end
                end
                FILL: begin
                    // The write on the port this cycle is the rectangle's last pixel
                    if (gen_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        bram_en   <= 1'b0;
                        bram_we   <= 1'b0;
                    end else begin
                        bram_addr <= gen_addr;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: directed corner cases plus random commands against a raster model.
module tb_fb_rect_writer;
    import vga_pkg::*;

    logic              clk_100m = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x0;
    logic [9:0]        cmd_y0;
    logic [9:0]        cmd_x1;
    logic [9:0]        cmd_y1;
    logic [PIX_W-1:0]  cmd_color;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              bram_we;
    logic [PIX_W-1:0]  bram_din;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_100m = ~clk_100m;

    fb_rect_writer dut (
        .clk_100m  (clk_100m),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_din  (bram_din)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
        cmd_x0    = 10'(x0);
        cmd_y0    = 10'(y0);
        cmd_x1    = 10'(x1);
        cmd_y1    = 10'(y1);
        cmd_color = PIX_W'(c);
    endtask

    task automatic scramble_cmd();
        cmd_x0    = 10'($urandom);
        cmd_y0    = 10'($urandom);
        cmd_x1    = 10'($urandom);
        cmd_y1    = 10'($urandom);
        cmd_color = PIX_W'($urandom);
    endtask

    function automatic bit cmd_ok(input int x0, input int y0, input int x1, input int y1);
        return (x0 <= x1) && (y0 <= y1) && (x1 < H_ACTIVE) && (y1 < V_ACTIVE);
    endfunction

    // Issue one command and check its whole response, ending one idle cycle after done/err
    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
        int q[$];
        @(negedge clk_100m);
        check_val("ready_before_cmd", cmd_ready, 1);
        set_cmd(x0, y0, x1, y1, c);
        cmd_valid = 1'b1;
        @(posedge clk_100m);
        #1;
        cmd_valid = 1'b0;
        scramble_cmd();
        if (!cmd_ok(x0, y0, x1, y1)) begin
            @(negedge clk_100m);
            check_val("rej_err", err, 1);
            check_val("rej_we", bram_we, 0);
            check_val("rej_ready", cmd_ready, 1);
            check_val("rej_busy", busy, 0);
            @(negedge clk_100m);
            check_val("rej_err_clear", err, 0);
            check_val("rej_we_after", bram_we, 0);
            check_val("rej_ready_after", cmd_ready, 1);
        end else begin
            for (int y = y0; y <= y1; y++)
                for (int x = x0; x <= x1; x++)
                    q.push_back(y * H_ACTIVE + x);
            for (int i = 0; i < q.size(); i++) begin
                @(negedge clk_100m);
                check_val("wr_addr", bram_addr, q[i]);
                check_val("wr_din", bram_din, c);
                check_val("wr_we", bram_we, 1);
                check_val("wr_en", bram_en, 1);
                check_val("wr_busy", busy, 1);
                check_val("wr_ready", cmd_ready, 0);
                check_val("wr_done", done, 0);
                scramble_cmd();
                cmd_valid = (i < q.size() - 1) ? 1'($urandom) : 1'b0;
            end
            @(negedge clk_100m);
            check_val("done_pulse", done, 1);
            check_val("done_we", bram_we, 0);
            check_val("done_en", bram_en, 0);
            check_val("done_ready", cmd_ready, 1);
            check_val("done_busy", busy, 0);
            @(negedge clk_100m);
            check_val("done_clear", done, 0);
            check_val("idle_we", bram_we, 0);
        end
    endtask

    initial begin
        int x0, y0, x1, y1, mode;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        set_cmd(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_100m);
        @(negedge clk_100m);
        check_val("rst_ready", cmd_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_en", bram_en, 0);
        check_val("rst_we", bram_we, 0);
        check_val("rst_addr", bram_addr, 0);
        check_val("rst_din", bram_din, 0);
        reset = 1'b0;

        run_cmd(5, 7, 5, 7, 9);
        run_cmd(638, 478, 639, 479, 15);
        run_cmd(0, 0, 639, 0, 3);
        run_cmd(100, 10, 100, 20, 6);
        run_cmd(0, 0, 640, 0, 1);
        run_cmd(10, 0, 3, 0, 1);
        run_cmd(0, 5, 0, 4, 1);
        run_cmd(0, 0, 0, 480, 1);
        run_cmd(0, 0, 639, 39, 0);

        // Reset part-way through a full-screen clear
        @(negedge clk_100m);
        set_cmd(0, 0, 639, 479, 0);
        cmd_valid = 1'b1;
        @(posedge clk_100m);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100m);
            check_val("clr_addr", bram_addr, i);
            check_val("clr_we", bram_we, 1);
        end
        reset = 1'b1;
        @(negedge clk_100m);
        check_val("abort_we", bram_we, 0);
        check_val("abort_ready", cmd_ready, 1);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_addr", bram_addr, 0);
        check_val("abort_din", bram_din, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100m);
            check_val("abort_no_done", done, 0);
            check_val("abort_no_we", bram_we, 0);
        end
        run_cmd(5, 7, 5, 7, 9);

        // Back-to-back with cmd_valid held: 2x1 rectangle then a single pixel
        @(negedge clk_100m);
        set_cmd(0, 0, 1, 0, 4);
        cmd_valid = 1'b1;
        @(posedge clk_100m);
        #1;
        set_cmd(3, 3, 3, 3, 11);
        @(negedge clk_100m);
        check_val("b2b_w1_addr", bram_addr, 0);
        check_val("b2b_w1_we", bram_we, 1);
        check_val("b2b_w1_din", bram_din, 4);
        check_val("b2b_w1_ready", cmd_ready, 0);
        @(negedge clk_100m);
        check_val("b2b_w2_addr", bram_addr, 1);
        check_val("b2b_w2_we", bram_we, 1);
        @(negedge clk_100m);
        check_val("b2b_done", done, 1);
        check_val("b2b_done_we", bram_we, 0);
        check_val("b2b_done_ready", cmd_ready, 1);
        @(posedge clk_100m);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk_100m);
        check_val("b2b_w3_addr", bram_addr, 3 * H_ACTIVE + 3);
        check_val("b2b_w3_we", bram_we, 1);
        check_val("b2b_w3_din", bram_din, 11);
        check_val("b2b_w3_done", done, 0);
        @(negedge clk_100m);
        check_val("b2b_done2", done, 1);
        check_val("b2b_done2_we", bram_we, 0);

        // Random mix of small legal rectangles and each kind of illegal command
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 5);
            x0 = $urandom_range(0, H_ACTIVE - 1);
            y0 = $urandom_range(0, V_ACTIVE - 1);
            x1 = x0 + $urandom_range(0, 7);
            y1 = y0 + $urandom_range(0, 5);
            if (x1 > H_ACTIVE - 1) x1 = H_ACTIVE - 1;
            if (y1 > V_ACTIVE - 1) y1 = V_ACTIVE - 1;
            case (mode)
                2: if (x0 > 0) x1 = $urandom_range(0, x0 - 1);
                3: if (y0 > 0) y1 = $urandom_range(0, y0 - 1);
                4: x1 = $urandom_range(H_ACTIVE, 1023);
                5: y1 = $urandom_range(V_ACTIVE, 1023);
                default: ;
            endcase
            run_cmd(x0, y0, x1, y1, $urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
